fpio_out_shifter: RTL and testbench
===================================

# fpio_out_shifter

Drain stage placed directly downstream of the fpio FIFO. It pops `DATA_WIDTH`-bit words from the FIFO read side using the FIFO's one-cycle `data_en`/`data_ack` pop handshake. It serializes each word onto `PIN_WIDTH` output pins, LSB-first, at a programmable beat rate. A one-word holding buffer is prefetched while the shifter runs, so consecutive words stream with no gap.

## Interface
Parameters:
- `DATA_WIDTH`, 32, FIFO word width; must be an integer multiple of `PIN_WIDTH`.
- `PIN_WIDTH`, 4, output pin-bus width.
- `FIFO_BITS`, 4, FIFO depth log2; sets the `fifo_avail` width.
- `DIV_BITS`, 8, width of the beat divider.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_data`  in  DATA_WIDTH  FIFO read data (the word at the FIFO head).
- `fifo_avail`  in  FIFO_BITS+1  FIFO occupancy.
- `fifo_data_en`  out  1  pop request, single-cycle pulse.
- `fifo_data_ack`  in  1  pop acknowledge.
- `enable`  in  1  permits fetching and starting new words.
- `clk_div`  in  DIV_BITS  beat length = `clk_div`+1 clk cycles.
- `pin_data`  out  PIN_WIDTH  current beat.
- `pin_valid`  out  1  `pin_data` is meaningful.
- `pin_strobe`  out  1  pulse in the first cycle of each beat.
- `busy`  out  1  shifting, or a fetch is outstanding.
- `underrun`  out  1  sticky flag; exists only when the configuration macro is defined.
- `underrun_clr`  in  1  clears `underrun`; exists only when the configuration macro is defined.

## Operation
- `BEATS` = `DATA_WIDTH`/`PIN_WIDTH`. The beat counter is $clog2(BEATS) bits wide. The divider counter is `DIV_BITS` wide.

Fetch FSM, states IDLE, REQ, WAIT_ACK, COOL:
- IDLE to REQ when `enable`=1, the holding buffer is empty, and `fifo_avail`≠0.
- REQ: `fifo_data_en`=1 for exactly one cycle, then the FSM moves to WAIT_ACK.
- WAIT_ACK: stays until `fifo_data_ack`=1. In the ack cycle it captures `fifo_data` into the holding buffer, sets `hold_valid`, and moves to COOL.
- COOL: one cycle so `fifo_avail` settles, then back to IDLE.
- `fifo_data_ack` outside WAIT_ACK is ignored.

Shift engine, states SIDLE, SHIFT:
- SIDLE to SHIFT when `hold_valid`=1 and `enable`=1. The holding word loads into the shifter, `hold_valid` clears, the divider is set to the `clk_div` value sampled at that point, and the beat counter is set to 0.
- SHIFT: `pin_data` = shifter[`PIN_WIDTH`-1:0] and `pin_valid`=1.
  - The divider counts down each cycle. When it reaches 0, the shifter shifts right by `PIN_WIDTH` and the beat counter increments.
  - `clk_div` is resampled only at word start.
- Last cycle of the last beat:
  - If `hold_valid`=1 and `enable`=1, the engine loads the next word on the same edge, so there is no gap.
  - Otherwise it goes to SIDLE and `pin_valid` drops next cycle.
- Holding-buffer load and clear in the same cycle: the clear wins for the old word and the load sets the flag, giving net `hold_valid`=1.
- `enable` low:
  - the current word completes;
  - no new fetch is issued;
  - a captured holding word is kept, not discarded;
  - an outstanding WAIT_ACK still completes.
- `busy` = (shift state ≠ SIDLE) | (fetch state ∈ {REQ, WAIT_ACK}).

## Timing
- Reset values:
  - `fifo_data_en`, `pin_data`, `pin_valid`, `pin_strobe`, `busy`, `underrun` are all 0.
  - Both FSMs are idle and `hold_valid`=0.
  - Reset mid-word aborts immediately; any ack arriving during or after reset is dropped.
- All outputs are registered.
- Cold start latency, with `fifo_avail` becoming non-zero in cycle 0:
  - `fifo_data_en` in cycle 1;
  - ack and capture in cycle 2;
  - shifter loads in cycle 3;
  - first beat with `pin_valid`=1 and `pin_strobe`=1 in cycle 4.
- The fetch period is at least 4 cycles. A word lasts `BEATS`×(`clk_div`+1) cycles. Back-to-back streaming therefore requires `BEATS`×(`clk_div`+1) ≥ 4; below that, gaps occur.
- `pin_strobe` pulses every `clk_div`+1 cycles while SHIFT. With `clk_div`=0 it is high on every SHIFT cycle.

## Configuration
- `FPIO_OUT_SHIFTER_UNDERRUN_EN`:
  - Defined:
    - `underrun` and `underrun_clr` ports exist.
    - `underrun` sets one cycle after a word finishes with `enable`=1 and `hold_valid`=0.
    - `underrun_clr` clears it; if set and clear coincide, set wins.
  - Undefined: the ports are absent and gaps occur silently.

## Test plan
- Reset, then FIFO holds word 0x87654321, `clk_div`=0, `enable`=1 -> `fifo_data_en` pulses once. `pin_valid` rises 4 cycles after avail. `pin_data` is 1,2,3,4,5,6,7,8 on 8 consecutive cycles, then `pin_valid`=0.
- FIFO preloaded with 0x76543210 and 0xFEDCBA98, `clk_div`=0 -> 16 consecutive `pin_valid` cycles, `pin_data` 0..F, exactly two `fifo_data_en` pulses.
- `clk_div`=2, one word -> each nibble held 3 cycles, `pin_strobe` every 3rd cycle, 24 valid cycles. Changing `clk_div` mid-word has no effect until the next word.
- Macro on, one word, FIFO then empty -> `underrun`=1 after the word, stays set; `underrun_clr` -> 0 next cycle.
- Two words queued, `enable` dropped at beat 3 of word 1 -> word 1 completes, word 2 stays held with no output. Raising `enable` -> word 2 starts 1 cycle later.
- `rst` asserted at beat 5 -> next cycle all outputs 0. Ack during `rst` is ignored, and no capture occurs after release.

Source files
------------

// File: rtl/fpio_out_shifter.sv
// fpio_out_shifter: pops words from the fpio FIFO and serializes them LSB-first onto pin_data.
// Optional sticky underrun flag: define FPIO_OUT_SHIFTER_UNDERRUN_EN.
//
//   fetch state | meaning
//   F_IDLE      | waiting for enable, empty holding buffer and FIFO data
//   F_REQ       | fifo_data_en pulse
//   F_WAIT_ACK  | waiting for fifo_data_ack, captures fifo_data
//   F_COOL      | one cycle for fifo_avail to settle
//   shift state | meaning
//   S_IDLE      | no word on the pins
//   S_SHIFT     | driving beats of the current word
module fpio_out_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int PIN_WIDTH  = 4,
  parameter int FIFO_BITS  = 4,
  parameter int DIV_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic [FIFO_BITS:0]    fifo_avail,
  output logic                  fifo_data_en,
  input  logic                  fifo_data_ack,
  input  logic                  enable,
  input  logic [DIV_BITS-1:0]   clk_div,
  output logic [PIN_WIDTH-1:0]  pin_data,
  output logic                  pin_valid,
  output logic                  pin_strobe,
  output logic                  busy
`ifdef FPIO_OUT_SHIFTER_UNDERRUN_EN
  ,
  output logic                  underrun,
  input  logic                  underrun_clr
`endif
);

  localparam int BEATS  = DATA_WIDTH / PIN_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT_ACK, F_COOL} fetch_t;
  typedef enum logic {S_IDLE, S_SHIFT} shift_t;

  fetch_t                fstate;
  shift_t                sstate;
  logic [DATA_WIDTH-1:0] hold_buf;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_shift;
  logic [DIV_BITS-1:0]   div_cnt;
  logic [DIV_BITS-1:0]   div_reload;
  logic [BEAT_W-1:0]     beat_cnt;

  logic fetch_go;
  logic capture;
  logic beat_end;
  logic word_end;
  logic start;
  logic shift_next;
  logic fetch_busy_next;

  assign shreg_shift = shreg >> PIN_WIDTH;

  always_comb begin
    fetch_go        = (fstate == F_IDLE) && enable && !hold_valid && (fifo_avail != '0);
    capture         = (fstate == F_WAIT_ACK) && fifo_data_ack;
    beat_end        = (sstate == S_SHIFT) && (div_cnt == '0);
    word_end        = beat_end && (beat_cnt == BEAT_LAST);
    start           = hold_valid && enable && ((sstate == S_IDLE) || word_end);
    shift_next      = start || ((sstate == S_SHIFT) && !word_end);
    fetch_busy_next = fetch_go || (fstate == F_REQ) ||
                      ((fstate == F_WAIT_ACK) && !fifo_data_ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate       <= F_IDLE;
      sstate       <= S_IDLE;
      hold_buf     <= '0;
      hold_valid   <= 1'b0;
      shreg        <= '0;
      div_cnt      <= '0;
      div_reload   <= '0;
      beat_cnt     <= '0;
      fifo_data_en <= 1'b0;
      pin_data     <= '0;
      pin_valid    <= 1'b0;
      pin_strobe   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (fstate)
        F_IDLE: begin
          if (fetch_go) begin
            fstate       <= F_REQ;
            fifo_data_en <= 1'b1;
          end
        end
        F_REQ: begin
          fstate       <= F_WAIT_ACK;
          fifo_data_en <= 1'b0;
        end
        F_WAIT_ACK: begin
          if (fifo_data_ack) begin
            fstate   <= F_COOL;
            hold_buf <= fifo_data;
          end
        end
        F_COOL:  fstate <= F_IDLE;
        default: fstate <= F_IDLE;
      endcase

      // a fresh capture outranks the consume of the previous word
      if (capture)
        hold_valid <= 1'b1;
      else if (start)
        hold_valid <= 1'b0;

      if (start) begin
        sstate     <= S_SHIFT;
        shreg      <= hold_buf;
        pin_data   <= hold_buf[PIN_WIDTH-1:0];
        div_cnt    <= clk_div;
        div_reload <= clk_div;
        beat_cnt   <= '0;
        pin_valid  <= 1'b1;
        pin_strobe <= 1'b1;
      end else if (word_end) begin
        sstate     <= S_IDLE;
        pin_data   <= '0;
        pin_valid  <= 1'b0;
        pin_strobe <= 1'b0;
      end else if (beat_end) begin
        shreg      <= shreg_shift;
        pin_data   <= shreg_shift[PIN_WIDTH-1:0];
        div_cnt    <= div_reload;
        beat_cnt   <= beat_cnt + BEAT_W'(1);
        pin_strobe <= 1'b1;
      end else if (sstate == S_SHIFT) begin
        div_cnt    <= div_cnt - DIV_BITS'(1);
        pin_strobe <= 1'b0;
      end

      busy <= shift_next || fetch_busy_next;
    end
  end

`ifdef FPIO_OUT_SHIFTER_UNDERRUN_EN
  always_ff @(posedge clk) begin
    if (rst)
      underrun <= 1'b0;
    else if (word_end && enable && !hold_valid)
      underrun <= 1'b1;
    else if (underrun_clr)
      underrun <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_fpio_out_shifter.sv
// Scoreboard bench for fpio_out_shifter: a FIFO model feeds words, expected beats are queued
// at push time and compared beat-by-beat as pin_valid cycles appear.
module tb_fpio_out_shifter;

  localparam int DW    = 32;
  localparam int PW    = 4;
  localparam int FB    = 4;
  localparam int DB    = 8;
  localparam int BEATS = DW / PW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_data;
  logic [FB:0]   fifo_avail;
  logic          fifo_data_en;
  logic          fifo_data_ack;
  logic          enable;
  logic [DB-1:0] clk_div;
  logic [PW-1:0] pin_data;
  logic          pin_valid;
  logic          pin_strobe;
  logic          busy;
`ifdef FPIO_OUT_SHIFTER_UNDERRUN_EN
  logic          underrun;
  logic          underrun_clr;
`endif

  fpio_out_shifter #(
    .DATA_WIDTH(DW), .PIN_WIDTH(PW), .FIFO_BITS(FB), .DIV_BITS(DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_data    (fifo_data),
    .fifo_avail   (fifo_avail),
    .fifo_data_en (fifo_data_en),
    .fifo_data_ack(fifo_data_ack),
    .enable       (enable),
    .clk_div      (clk_div),
    .pin_data     (pin_data),
    .pin_valid    (pin_valid),
    .pin_strobe   (pin_strobe),
    .busy         (busy)
`ifdef FPIO_OUT_SHIFTER_UNDERRUN_EN
    ,
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int valid_cnt, strobe_cnt, en_cnt, vfirst, vlast;

  logic [DW-1:0] fifo_q[$];
  logic [PW:0]   exp_q[$];
  logic [PW:0]   exp_e;
  logic          auto_ack = 1'b1;
  logic          ack_pend = 1'b0;
  logic          mon_en   = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic upd_fifo();
    fifo_avail = (FB + 1)'(fifo_q.size());
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    for (int b = 0; b < BEATS; b++)
      for (int r = 0; r <= int'(clk_div); r++)
        exp_q.push_back({(r == 0), w[b*PW +: PW]});
    upd_fifo();
  endtask

  task automatic clr_stats();
    valid_cnt  = 0;
    strobe_cnt = 0;
    en_cnt     = 0;
    vfirst     = 0;
    vlast      = 0;
  endtask

  task automatic wait_quiet(input string tag);
    int run = 0;
    for (int i = 0; i < 400 && run < 3; i++) begin
      @(negedge clk);
      if (!busy && !pin_valid && !fifo_data_en) run++;
      else run = 0;
    end
    chk({tag, "_settle"}, 32'(run >= 3), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (pin_valid) seen = 1;
    end
    chk({tag, "_start"}, 32'(seen), 32'd1);
  endtask

  // FIFO read side: ack one cycle after the data_en pulse, pop after the ack cycle
  always @(negedge clk) begin
    if (auto_ack) begin
      if (fifo_data_ack && fifo_q.size() > 0) fifo_q.delete(0);
      fifo_data_ack = ack_pend;
      ack_pend      = fifo_data_en;
      upd_fifo();
    end
  end

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (fifo_data_en) en_cnt++;
      if (pin_strobe) strobe_cnt++;
      if (pin_valid) begin
        if (valid_cnt == 0) vfirst = cyc;
        vlast = cyc;
        valid_cnt++;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_e = exp_q.pop_front();
          chk("pin_data", 32'(pin_data), 32'(exp_e[PW-1:0]));
          chk("pin_strobe", 32'(pin_strobe), 32'(exp_e[PW]));
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    clk_div       = '0;
    fifo_data_ack = 1'b0;
`ifdef FPIO_OUT_SHIFTER_UNDERRUN_EN
    underrun_clr  = 1'b0;
`endif
    upd_fifo();
    clr_stats();

    repeat (3) @(negedge clk);
    chk("rst_data_en", 32'(fifo_data_en), 32'd0);
    chk("rst_valid", 32'(pin_valid), 32'd0);
    chk("rst_strobe", 32'(pin_strobe), 32'd0);
    chk("rst_pin_data", 32'(pin_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef FPIO_OUT_SHIFTER_UNDERRUN_EN
    chk("rst_underrun", 32'(underrun), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // single word, cold-start latency
    enable = 1'b1;
    clr_stats();
    push_word(32'h87654321);
    @(negedge clk); chk("lat_en_c1", 32'(fifo_data_en), 32'd1);
    @(negedge clk); chk("lat_en_c2", 32'(fifo_data_en), 32'd0);
    @(negedge clk); chk("lat_valid_c3", 32'(pin_valid), 32'd0);
    @(negedge clk); chk("lat_valid_c4", 32'(pin_valid), 32'd1);
    chk("lat_strobe_c4", 32'(pin_strobe), 32'd1);
    wait_quiet("w1");
    chk("w1_valid_cnt", 32'(valid_cnt), 32'd8);
    chk("w1_en_cnt", 32'(en_cnt), 32'd1);
    chk("w1_contig", 32'(vlast - vfirst + 1), 32'(valid_cnt));
    chk("w1_sb_empty", 32'(exp_q.size()), 32'd0);

    // two preloaded words stream back-to-back
    enable = 1'b0;
    clr_stats();
    push_word(32'h76543210);
    push_word(32'hFEDCBA98);
    @(negedge clk);
    enable = 1'b1;
    wait_quiet("w2");
    chk("w2_valid_cnt", 32'(valid_cnt), 32'd16);
    chk("w2_en_cnt", 32'(en_cnt), 32'd2);
    chk("w2_strobe_cnt", 32'(strobe_cnt), 32'd16);
    chk("w2_contig", 32'(vlast - vfirst + 1), 32'(valid_cnt));

    // clk_div=2, changed mid-word
    clk_div = 8'd2;
    clr_stats();
    push_word(32'h13579BDF);
    wait_valid("div");
    repeat (4) @(negedge clk);
    clk_div = 8'd0;
    wait_quiet("div");
    chk("div_valid_cnt", 32'(valid_cnt), 32'd24);
    chk("div_strobe_cnt", 32'(strobe_cnt), 32'd8);
    chk("div_contig", 32'(vlast - vfirst + 1), 32'(valid_cnt));

    // enable dropped mid-word: word 2 held until enable returns
    clr_stats();
    push_word(32'h0F1E2D3C);
    push_word(32'h4B5A6978);
    wait_valid("hold");
    repeat (2) @(negedge clk);
    enable = 1'b0;
    wait_quiet("hold");
    repeat (5) @(negedge clk);
    chk("hold_valid_cnt", 32'(valid_cnt), 32'd8);
    chk("hold_en_cnt", 32'(en_cnt), 32'd2);
    chk("hold_no_out", 32'(pin_valid), 32'd0);
    chk("hold_sb_left", 32'(exp_q.size()), 32'd8);
    enable = 1'b1;
    @(negedge clk);
    chk("resume_latency", 32'(pin_valid), 32'd1);
    wait_quiet("resume");
    chk("resume_valid_cnt", 32'(valid_cnt), 32'd16);
    chk("resume_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef FPIO_OUT_SHIFTER_UNDERRUN_EN
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("ur_pre_clear", 32'(underrun), 32'd0);
    clr_stats();
    push_word(32'hA5A5C3C3);
    wait_valid("ur");
    wait_quiet("ur");
    chk("ur_set", 32'(underrun), 32'd1);
    repeat (3) @(negedge clk);
    chk("ur_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("ur_cleared", 32'(underrun), 32'd0);
`endif

    // reset mid-word, ack held through and after reset
    clr_stats();
    push_word(32'h11223344);
    push_word(32'h55667788);
    wait_valid("rstm");
    repeat (4) @(negedge clk);
    rst           = 1'b1;
    enable        = 1'b0;
    mon_en        = 1'b0;
    auto_ack      = 1'b0;
    fifo_data_ack = 1'b1;
    @(negedge clk);
    chk("rstm_valid", 32'(pin_valid), 32'd0);
    chk("rstm_strobe", 32'(pin_strobe), 32'd0);
    chk("rstm_pin_data", 32'(pin_data), 32'd0);
    chk("rstm_data_en", 32'(fifo_data_en), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
`ifdef FPIO_OUT_SHIFTER_UNDERRUN_EN
    chk("rstm_underrun", 32'(underrun), 32'd0);
`endif
    fifo_q.delete();
    exp_q.delete();
    push_word(32'hDEADBEEF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(pin_valid), 32'd0);
    fifo_data_ack = 1'b0;
    ack_pend      = 1'b0;
    auto_ack      = 1'b1;
    mon_en        = 1'b1;
    clr_stats();
    enable = 1'b1;
    @(negedge clk);
    chk("post_rst_fetch", 32'(fifo_data_en), 32'd1);
    chk("post_rst_no_capture", 32'(pin_valid), 32'd0);
    wait_quiet("post_rst");
    chk("post_rst_valid_cnt", 32'(valid_cnt), 32'd8);
    chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
